// File: rtl/dll_fc_init_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dll_fc_init_ctrl
//  Description : Data Link Control and Management State Machine with the
//                flow-control initialisation handshake.
//                IDLE -> INIT1 -> INIT2 -> ACTIVE.
//                INIT1/INIT2 transmit InitFC1/InitFC2 DLLPs for P, NP and Cpl,
//                resend the set after RESEND_CYCLES idle cycles, capture the
//                partner's advertised credits and raise dl_up_o in ACTIVE.
//  Ports       : clk, rst            - clock, async active-high reset
//                link_up_i           - physical link up (low forces IDLE)
//                adv_hdr/dat_crd_i   - our credits to advertise, {Cpl,NP,P}
//                tx_data/valid_o,
//                tx_ready_i          - outgoing DLLP valid/ready channel
//                rx_data/valid_i,
//                rx_ready_o          - incoming DLLP valid/ready channel
//                rem_hdr/dat_crd_o   - captured partner credits, {Cpl,NP,P}
//                state_o             - 0 IDLE, 1 INIT1, 2 INIT2, 3 ACTIVE
//                dl_up_o             - high in ACTIVE
//  DLLP layout : [7:0] type, [8+:HDR_CW] HdrFC, [16+:DAT_CW] DataFC, rest 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module dll_fc_init_ctrl #(
  parameter int DATA_W        = 256,  // >= 32
  parameter int HDR_CW        = 8,
  parameter int DAT_CW        = 12,
  parameter int RESEND_CYCLES = 16    // >= 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  link_up_i,
  input  logic [3*HDR_CW-1:0]   adv_hdr_crd_i,
  input  logic [3*DAT_CW-1:0]   adv_dat_crd_i,
  output logic [DATA_W-1:0]     tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [DATA_W-1:0]     rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [3*HDR_CW-1:0]   rem_hdr_crd_o,
  output logic [3*DAT_CW-1:0]   rem_dat_crd_o,
  output logic [1:0]            state_o,
  output logic                  dl_up_o
);

  localparam int TMR_W = $clog2(RESEND_CYCLES + 1);
  localparam logic [TMR_W-1:0] RESEND_LOAD = TMR_W'(RESEND_CYCLES);

  // Bits of an incoming DLLP that carry meaning; the rest are ignored.
  localparam logic [DATA_W-1:0] RX_USED_MASK =
      ((DATA_W'(1) << (16 + DAT_CW)) - (DATA_W'(1) << 16)) |
      ((DATA_W'(1) << (8 + HDR_CW))  - (DATA_W'(1) << 8))  |
      DATA_W'(8'hFF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT1  = 2'd1,
    ST_INIT2  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       idx;        // 0 = P, 1 = NP, 2 = Cpl
  logic             sent_set;   // full set accepted in the current phase
  logic [TMR_W-1:0] timer;      // resend gap countdown
  logic [2:0]       got1;       // partner credits captured per type
  logic [2:0]       got2;       // partner InitFC2 seen per type

  assign state_o = state;

  // --------------------------------------------------------------------------
  // Handshake and receive decode
  // --------------------------------------------------------------------------
  logic              tx_fire;
  logic              rx_fire;
  logic [7:0]        rx_type;
  logic [HDR_CW-1:0] rx_hdr;
  logic [DAT_CW-1:0] rx_dat;
  logic [2:0]        rx_hit;     // accepted InitFC1/InitFC2 per type
  logic [2:0]        rx_fc2_hit; // accepted InitFC2 per type
  logic [2:0]        cap;
  logic [2:0]        got1_nxt;
  logic [2:0]        got2_nxt;
  logic              unused_rx_bits;

  assign tx_fire = tx_valid_o && tx_ready_i;
  assign rx_fire = rx_valid_i && rx_ready_o;
  assign rx_type = rx_data_i[7:0];
  assign rx_hdr  = rx_data_i[8 +: HDR_CW];
  assign rx_dat  = rx_data_i[16 +: DAT_CW];
  assign unused_rx_bits = |(rx_data_i & ~RX_USED_MASK);

  always_comb begin
    rx_hit     = 3'b000;
    rx_fc2_hit = 3'b000;
    if (rx_fire) begin
      case (rx_type)
        8'h40, 8'hC0: rx_hit = 3'b001;
        8'h50, 8'hD0: rx_hit = 3'b010;
        8'h60, 8'hE0: rx_hit = 3'b100;
        default:      rx_hit = 3'b000;  // unknown types are dropped
      endcase
      if (rx_type[7]) begin
        rx_fc2_hit = rx_hit;
      end
    end
  end

  // First arrival of either InitFC flavour wins; duplicates never overwrite.
  assign cap      = rx_hit & ~got1;
  assign got1_nxt = got1 | rx_hit;
  assign got2_nxt = got2 | rx_fc2_hit;

  // --------------------------------------------------------------------------
  // Phase transition conditions (a same-cycle capture or final acceptance
  // already counts toward the condition)
  // --------------------------------------------------------------------------
  logic sent_nxt;
  logic no_pend;
  logic go_init2;
  logic go_active;

  assign sent_nxt  = sent_set || (tx_fire && (idx == 2'd2));
  assign no_pend   = !tx_valid_o || tx_fire;
  assign go_init2  = (state == ST_INIT1) && sent_nxt && (&got1_nxt) && no_pend;
  assign go_active = (state == ST_INIT2) && sent_nxt && (&got2_nxt) && no_pend;

  // --------------------------------------------------------------------------
  // Next beat to launch: either the follower of an accepted P/NP beat, or
  // a fresh set starting at P (new phase, resend, entry from IDLE).
  // --------------------------------------------------------------------------
  logic              launch_fc2;
  logic [1:0]        launch_idx;
  logic [HDR_CW-1:0] launch_hdr;
  logic [DAT_CW-1:0] launch_dat;
  logic [DATA_W-1:0] launch_data;

  always_comb begin
    launch_fc2 = (state == ST_INIT2) || go_init2;
    launch_idx = 2'd0;
    if (tx_fire && (idx != 2'd2) && !go_init2 && !go_active) begin
      launch_idx = idx + 2'd1;
    end
    case (launch_idx)
      2'd0: begin
        launch_hdr = adv_hdr_crd_i[0 +: HDR_CW];
        launch_dat = adv_dat_crd_i[0 +: DAT_CW];
      end
      2'd1: begin
        launch_hdr = adv_hdr_crd_i[HDR_CW +: HDR_CW];
        launch_dat = adv_dat_crd_i[DAT_CW +: DAT_CW];
      end
      default: begin
        launch_hdr = adv_hdr_crd_i[2*HDR_CW +: HDR_CW];
        launch_dat = adv_dat_crd_i[2*DAT_CW +: DAT_CW];
      end
    endcase
    launch_data              = '0;
    // 0x40/0x50/0x60 for InitFC1, bit 7 set for InitFC2
    launch_data[7:0]         = {launch_fc2, 3'(3'd4 + {1'b0, launch_idx}), 4'h0};
    launch_data[8 +: HDR_CW] = launch_hdr;
    launch_data[16 +: DAT_CW] = launch_dat;
  end

  // --------------------------------------------------------------------------
  // State machine, TX sequencer and credit capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      tx_valid_o    <= 1'b0;
      tx_data_o     <= '0;
      rx_ready_o    <= 1'b0;
      rem_hdr_crd_o <= '0;
      rem_dat_crd_o <= '0;
      dl_up_o       <= 1'b0;
      idx           <= 2'd0;
      sent_set      <= 1'b0;
      timer         <= '0;
      got1          <= 3'b000;
      got2          <= 3'b000;
    end else if ((state != ST_IDLE) && !link_up_i) begin
      // Link loss overrides everything, including a pending beat.
      state         <= ST_IDLE;
      tx_valid_o    <= 1'b0;
      tx_data_o     <= '0;
      rx_ready_o    <= 1'b0;
      rem_hdr_crd_o <= '0;
      rem_dat_crd_o <= '0;
      dl_up_o       <= 1'b0;
      idx           <= 2'd0;
      sent_set      <= 1'b0;
      timer         <= '0;
      got1          <= 3'b000;
      got2          <= 3'b000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (link_up_i) begin
            state      <= ST_INIT1;
            tx_valid_o <= 1'b1;
            tx_data_o  <= launch_data;
            rx_ready_o <= 1'b1;
          end
        end

        ST_INIT1, ST_INIT2: begin
          for (int t = 0; t < 3; t++) begin
            if (cap[t]) begin
              rem_hdr_crd_o[t*HDR_CW +: HDR_CW] <= rx_hdr;
              rem_dat_crd_o[t*DAT_CW +: DAT_CW] <= rx_dat;
            end
          end
          got1 <= got1_nxt;
          got2 <= got2_nxt;  // InitFC2 seen during INIT1 carries over

          if (go_init2) begin
            state      <= ST_INIT2;
            sent_set   <= 1'b0;
            idx        <= 2'd0;
            timer      <= '0;
            tx_valid_o <= 1'b1;
            tx_data_o  <= launch_data;
          end else if (go_active) begin
            state      <= ST_ACTIVE;
            sent_set   <= 1'b0;
            idx        <= 2'd0;
            timer      <= '0;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
            rx_ready_o <= 1'b0;
            dl_up_o    <= 1'b1;
          end else if (tx_fire) begin
            if (idx == 2'd2) begin
              sent_set   <= 1'b1;
              timer      <= RESEND_LOAD;
              tx_valid_o <= 1'b0;
              idx        <= 2'd0;
            end else begin
              idx       <= idx + 2'd1;
              tx_data_o <= launch_data;
            end
          end else if (!tx_valid_o) begin
            // Relaunch on the edge that ends the last idle cycle so that
            // exactly RESEND_CYCLES cycles stay idle.
            if (timer > TMR_W'(1)) begin
              timer <= timer - TMR_W'(1);
            end else begin
              timer      <= '0;
              tx_valid_o <= 1'b1;
              tx_data_o  <= launch_data;
            end
          end
        end

        default: begin
          // ACTIVE: credits and dl_up held until the link drops
        end
      endcase
    end
  end

endmodule
`default_nettype wire
